cam_pixel_packer: RTL and testbench

//  Camera-side capture stage downstream of the simulation camera model. Samples hsync/vsync/pixels
//  in the pixel-clock domain, takes one 8-bit pixel per PIX_DIV clocks in active video, packs 4

---
 rtl/cam_pixel_packer.sv | 207 ++++++++++++++++++++
 tb/tb_cam_pixel_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_packer.sv
// Camera capture stage: samples sync/pixel inputs in the pixel clock domain,
// packs four 8-bit pixels per 32-bit word into a small output FIFO with
// sof/eol markers, and tracks line/frame geometry errors.
//
// state  | meaning
// IDLE   | waiting for a vsync rise with enable=1
// FRAME  | inside an active frame, horizontal blanking
// LINE   | inside an active line, sampling pixels
`timescale 1ns/1ps
module cam_pixel_packer #(
   parameter int COLS    = 64,
   parameter int ROWS    = 8,
   parameter int PIX_DIV = 2,
   parameter int DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [7:0]  pixels,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sof,
   output logic        out_eol,
   output logic [15:0] frame_cnt,
   output logic [11:0] line_cnt,
   output logic        line_err,
   output logic        ovf,
   input  logic        clr_err
);

   localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW-1:0] PH_LAST  = PW'(PIX_DIV - 1);
   localparam logic [PW-1:0] PH_FIRST = (PIX_DIV > 1) ? PW'(1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_LINE} state_t;

   state_t         state;
   logic           h_q, v_q;
   logic [PW-1:0]  phase;
   logic [15:0]    pix_cnt;
   logic [31:0]    word_buf;
   logic           sof_pend;
   logic           stg_valid, stg_sof, stg_eol;
   logic [31:0]    stg_data;

   logic           h_rise, h_fall, v_rise, v_fall;
   logic           sample, line_end, frame_end;
   logic [1:0]     lane;
   logic [11:0]    lines_done;
   logic           len_bad, cnt_bad;

   logic [33:0]    fifo_mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           full, pop, do_push, drop;

   assign h_rise = hsync & ~h_q;
   assign h_fall = ~hsync & h_q;
   assign v_rise = vsync & ~v_q;
   assign v_fall = ~vsync & v_q;
   assign lane   = pix_cnt[1:0];

   // The first pixel of a line is taken on the hsync rise cycle itself (phase 0).
   assign sample    = vsync & hsync &
                      (((state == S_LINE) && (phase == '0)) || ((state == S_FRAME) && h_rise));
   assign line_end  = (state == S_LINE) && (v_fall || h_fall);
   assign frame_end = (state != S_IDLE) && v_fall;

   // Geometry checks evaluated on the cycle a line or frame closes.
   always_comb begin
      lines_done = line_cnt + ((state == S_LINE) ? 12'd1 : 12'd0);
      len_bad    = line_end && (pix_cnt != 16'(COLS));
      cnt_bad    = frame_end && (lines_done != 12'(ROWS));
   end

   // Sync edge registers, capture FSM, pixel packer and line/frame counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         // Preset high so a sync already high at reset release is not seen as a rise.
         h_q       <= 1'b1;
         v_q       <= 1'b1;
         phase     <= '0;
         pix_cnt   <= '0;
         word_buf  <= '0;
         sof_pend  <= 1'b0;
         stg_valid <= 1'b0;
         stg_sof   <= 1'b0;
         stg_eol   <= 1'b0;
         stg_data  <= '0;
         line_cnt  <= '0;
         frame_cnt <= '0;
      end else begin
         h_q       <= hsync;
         v_q       <= vsync;
         stg_valid <= 1'b0;
         stg_sof   <= 1'b0;
         stg_eol   <= 1'b0;

         if (sample) begin
            word_buf[{lane, 3'b000} +: 8] <= pixels;
            pix_cnt <= pix_cnt + 16'd1;
            if (lane == 2'd3) begin
               stg_valid <= 1'b1;
               stg_data  <= {pixels, word_buf[23:0]};
               stg_eol   <= (pix_cnt == 16'(COLS - 1));
               stg_sof   <= sof_pend;
               sof_pend  <= 1'b0;
               word_buf  <= '0;
            end
         end

         case (state)
            S_IDLE: begin
               if (v_rise && enable) begin
                  state    <= S_FRAME;
                  sof_pend <= 1'b1;
                  line_cnt <= '0;
                  pix_cnt  <= '0;
                  word_buf <= '0;
               end
            end
            S_FRAME: begin
               if (v_fall) begin
                  state     <= S_IDLE;
                  frame_cnt <= frame_cnt + 16'd1;
                  line_cnt  <= '0;
               end else if (h_rise) begin
                  state <= S_LINE;
                  phase <= PH_FIRST;
               end
            end
            S_LINE: begin
               if (v_fall || h_fall) begin
                  // Unused upper lanes of word_buf are already zero.
                  if (lane != 2'd0) begin
                     stg_valid <= 1'b1;
                     stg_data  <= word_buf;
                     stg_eol   <= 1'b1;
                     stg_sof   <= sof_pend;
                     sof_pend  <= 1'b0;
                  end
                  pix_cnt  <= '0;
                  word_buf <= '0;
                  if (v_fall) begin
                     state     <= S_IDLE;
                     frame_cnt <= frame_cnt + 16'd1;
                     line_cnt  <= '0;
                  end else begin
                     state    <= S_FRAME;
                     line_cnt <= line_cnt + 12'd1;
                  end
               end else begin
                  phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign full    = (count == (AW+1)'(DEPTH));
   assign pop     = (count != '0) && out_ready;
   assign do_push = stg_valid && (!full || pop);
   assign drop    = stg_valid && full && !pop;

   // Output FIFO; a push into a full FIFO is accepted only when the head pops that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (do_push) begin
            fifo_mem[wr_ptr] <= {stg_sof, stg_eol, stg_data};
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !pop)      count <= count + (AW+1)'(1);
         else if (!do_push && pop) count <= count - (AW+1)'(1);
      end
   end

   assign out_valid = (count != '0);
   assign {out_sof, out_eol, out_data} = fifo_mem[rd_ptr];

   // Sticky error flags; a set event in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_err <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (clr_err) begin
            line_err <= 1'b0;
            ovf      <= 1'b0;
         end
         if (len_bad || cnt_bad) line_err <= 1'b1;
         if (drop)               ovf      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer with an expected-word scoreboard.
`timescale 1ns/1ps
module tb_cam_pixel_packer;

   localparam int COLS = 64;
   localparam int ROWS = 8;
   localparam int PIX_DIV = 2;

   logic        clk = 1'b0;
   logic        reset, enable, hsync, vsync, out_ready, clr_err;
   logic [7:0]  pixels;
   logic [31:0] out_data;
   logic        out_valid, out_sof, out_eol, line_err, ovf;
   logic [15:0] frame_cnt;
   logic [11:0] line_cnt;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q [$];
   bit sof_next = 0;

   cam_pixel_packer #(.COLS(COLS), .ROWS(ROWS), .PIX_DIV(PIX_DIV), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .hsync(hsync), .vsync(vsync),
      .pixels(pixels), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
      .line_err(line_err), .ovf(ovf), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every accepted word is compared with the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_word", {out_sof, out_eol, out_data}, 34'h3_FFFF_FFFF ^ {out_sof, out_eol, out_data});
         else chk("word", {out_sof, out_eol, out_data}, exp_q.pop_front());
      end
   end

   // Drives one line of pixels 0,1,.. and queues the first `keep` words it should yield.
   task automatic drive_line(input int npix, input int keep);
      int nw;
      logic [31:0] d;
      bit e;
      nw = (npix + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         d = '0;
         for (int b = 0; b < 4; b++) begin
            int p;
            p = 4 * w + b;
            if (p < npix) d[8*b +: 8] = p[7:0];
         end
         e = ((4 * w + 3 == COLS - 1) && npix >= COLS) || ((w == nw - 1) && (npix % 4 != 0));
         if (w < keep) begin
            exp_q.push_back({sof_next, e, d});
            sof_next = 0;
         end
      end
      hsync = 1'b1;
      for (int p = 0; p < npix; p++) begin
         pixels = p[7:0];
         tick(PIX_DIV);
      end
      hsync = 1'b0;
      pixels = 8'h00;
      tick(6);
   endtask

   task automatic frame(input int nlines, input int short_idx, input int stall_idx, input bit capture);
      vsync = 1'b1;
      if (capture) sof_next = 1;
      tick(3);
      for (int l = 0; l < nlines; l++) begin
         if (l == stall_idx) out_ready = 1'b0;
         drive_line((l == short_idx) ? 62 : COLS, !capture ? 0 : (l == stall_idx) ? 4 : 1000);
         if (l == stall_idx) begin
            chk("stall_ovf", ovf, 1);
            chk("stall_valid", out_valid, 1);
            out_ready = 1'b1;
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            chk("stall_ovf_clr", ovf, 0);
         end
         if (l == short_idx) begin
            chk("short_line_err", line_err, 1);
            chk("short_line_cnt", line_cnt, l + 1);
            clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
            chk("short_err_clr", line_err, 0);
         end
         if (!capture && l == 0) enable = 1'b1;
      end
      vsync = 1'b0;
      tick(4);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; hsync = 1'b0; vsync = 1'b0;
      pixels = 8'h00; out_ready = 1'b1; clr_err = 1'b0;
      tick(3);
      reset = 1'b0;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_line_cnt", line_cnt, 0);
      chk("rst_line_err", line_err, 0);
      chk("rst_ovf", ovf, 0);

      // Full frame, free-flowing consumer.
      frame(ROWS, -1, -1, 1);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_line_cnt", line_cnt, 0);
      chk("t1_line_err", line_err, 0);
      chk("t1_ovf", ovf, 0);

      // Consumer stalled for a whole line.
      frame(ROWS, -1, 0, 1);
      chk("t2_frame_cnt", frame_cnt, 2);
      chk("t2_line_err", line_err, 0);

      // One 62-pixel line.
      frame(ROWS, 2, -1, 1);
      chk("t3_frame_cnt", frame_cnt, 3);
      chk("t3_line_err", line_err, 0);

      // Frame ends after 7 lines.
      frame(ROWS - 1, -1, -1, 1);
      chk("t4_line_err", line_err, 1);
      chk("t4_frame_cnt", frame_cnt, 4);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // Enable low at frame start, raised mid-frame: frame ignored, next one captured.
      enable = 1'b0;
      frame(ROWS, -1, -1, 0);
      chk("t5_ignored_frame_cnt", frame_cnt, 4);
      chk("t5_ignored_queue", exp_q.size(), 0);
      frame(ROWS, -1, -1, 1);
      chk("t5_frame_cnt", frame_cnt, 5);

      // Reset mid-line with vsync held high.
      vsync = 1'b1;
      tick(3);
      exp_q.push_back({2'b10, 32'h0302_0100});
      exp_q.push_back({2'b00, 32'h0706_0504});
      hsync = 1'b1;
      for (int p = 0; p < 10; p++) begin
         pixels = p[7:0];
         tick(PIX_DIV);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_valid", out_valid, 0);
      chk("t6_frame_cnt", frame_cnt, 0);
      chk("t6_line_cnt", line_cnt, 0);
      chk("t6_queue", exp_q.size(), 0);
      for (int p = 10; p < COLS; p++) begin
         pixels = p[7:0];
         tick(PIX_DIV);
      end
      hsync = 1'b0;
      tick(6);
      drive_line(COLS, 0);
      vsync = 1'b0;
      tick(4);
      chk("t6_after_frame_cnt", frame_cnt, 0);
      chk("t6_after_valid", out_valid, 0);
      chk("t6_after_line_err", line_err, 0);
      frame(ROWS, -1, -1, 1);
      chk("t6_recover_frame_cnt", frame_cnt, 1);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      chk("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
